q_update_engine: RTL and testbench
==================================

Name: q_update_engine

Overview:
- Write-side companion to the Q-table RAM. It accepts one experience transition (s, a, r, s', terminal) over a valid/ready handshake.
- It scans Q(s', ·) through the RAM's two registered read ports to find max Q(s', a').
- It computes the Q-learning update with shift-based alpha and gamma, then writes Q(s, a) back through the RAM's negedge write port.
- It sits between the agent/environment controller and the Q-table RAM, and is the only writer of that RAM.

Parameters:
- DATA_WIDTH, 16: signed Q-value width, Q8.8 fixed point (1.0 = 0x0100).
- STATES_WIDTH, 4: state index width.
- ACTION_WIDTH, 2: action index width; NUM_ACTIONS = 2**ACTION_WIDTH.
- ALPHA_SHIFT, 2: learning rate alpha = 2^-ALPHA_SHIFT.
- GAMMA_SHIFT, 3: discount gamma = 1 - 2^-GAMMA_SHIFT (0.875).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  transition present.
- in_ready  out  1  engine idle, can accept a transition.
- in_state  in  STATES_WIDTH  s.
- in_action  in  ACTION_WIDTH  a.
- in_reward  in  DATA_WIDTH  r, signed Q8.8.
- in_next_state  in  STATES_WIDTH  s'.
- in_terminal  in  1  s' is terminal; future term forced to 0.
- ram_we  out  1  RAM write enable; the RAM samples it on negedge.
- ram_addr_cur  out  STATES_WIDTH+ACTION_WIDTH  {s,a}; drives both read and write address.
- ram_addr_nxt  out  STATES_WIDTH+ACTION_WIDTH  {s',i}; scan read address.
- ram_wdata  out  DATA_WIDTH  updated Q(s,a).
- ram_q_cur  in  DATA_WIDTH  registered RAM read of ram_addr_cur.
- ram_q_nxt  in  DATA_WIDTH  registered RAM read of ram_addr_nxt.
- done  out  1  one-cycle pulse when the write is issued.
- best_action  out  ACTION_WIDTH  argmax of Q(s', ·) from the last update.

Behaviour:
- Reset (async, rst_n=0) forces:
  - FSM to IDLE, in_ready=1.
  - ram_we=0, done=0.
  - ram_addr_cur=0, ram_addr_nxt=0, ram_wdata=0, best_action=0.
  - Internal max register and counter to 0.
- Reset mid-operation abandons the transition; no write is ever issued for it.
- RAM read latency: an address registered at posedge k returns data after posedge k+1, so it is usable at posedge k+2. The engine accounts for the 1-cycle read pipeline.
- Handshake:
  - Accept occurs on a posedge with in_valid & in_ready (cycle 0). All inputs are latched then.
  - in_ready is 0 from cycle 1 until the FSM returns to IDLE.
  - in_valid while busy is ignored.
- IDLE: in_ready=1. On accept, set ram_addr_cur={s,a}, ram_addr_nxt={s',0}, cnt=0, and go to SCAN.
- SCAN (cycles 1..NUM_ACTIONS+1):
  - Each cycle, advance ram_addr_nxt to {s',cnt+1} while cnt+1 < NUM_ACTIONS.
  - From cycle 2 onward, compare ram_q_nxt (index cnt-1) against the running max, signed strict greater-than. Index 0 initialises the max. Ties keep the lower action index.
  - Capture ram_q_cur during SCAN.
  - After the last index is compared, go to CALC.
- CALC (cycle NUM_ACTIONS+2), all arithmetic signed at DATA_WIDTH+2 bits:
  - fut = terminal ? 0 : max − (max >>> GAMMA_SHIFT).
  - td = r + fut − q_cur.
  - q_new = q_cur + (td >>> ALPHA_SHIFT), arithmetic shift.
  - Result is narrowed per the optional feature. Register ram_wdata and best_action.
- WRITE (cycle NUM_ACTIONS+3; cycle 7 by default):
  - ram_we=1 and done=1 for exactly one cycle, with ram_addr_cur holding {s,a}.
  - Next state is IDLE; in_ready=1 from cycle NUM_ACTIONS+4.
- Self-loop (s==s' with a in scan): the scan uses the pre-update value (read before write).
- Back-to-back: the next accept occurs no earlier than cycle NUM_ACTIONS+4. Its reads see the prior write, since the write landed on the WRITE-cycle negedge.

Optional Feature:
- Macro: QUPD_SATURATE_EN.
- Defined: q_new is clamped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] (0x8000..0x7FFF).
- Undefined: q_new is truncated to its low DATA_WIDTH bits (two's-complement wrap).
- Scan and latency are identical in both cases.

Decomposition:
- Package q_pkg holds:
  - DATA_WIDTH, STATES_WIDTH, ACTION_WIDTH, derived ADDR_WIDTH and NUM_ACTIONS.
  - Q8.8 constants (Q_ONE=0x0100, Q_MAX, Q_MIN).
  - FSM enum {IDLE, SCAN, CALC, WRITE}.
- One sub-module, q_max_scan: a running signed max with argmax. Inputs are start/valid/value/index; outputs are max and best index.

Test Plan:
- Preload Q(2,1)=0x0100 and Q(3,0..3)={0x0080,0x0200,0xFF00,0x0000}. Send s=2, a=1, r=0x0100, s'=3, terminal=0. Required: ram_we at cycle 7, addr {2,1}, wdata=0x0170, best_action=1, done 1 cycle.
- Same preload and inputs with terminal=1 -> wdata=0x0100 (td=0).
- Q(s,a)=0x7F00, r=0x7F00, all Q(s',·)=0x7F00 -> 0x7FFF with QUPD_SATURATE_EN, 0x9AC8 without.
- Drop rst_n at SCAN cycle 3 -> ram_we never asserts, done=0; in_ready=1 immediately and after release; outputs at reset values.
- Hold in_valid high across two transitions -> second accepted at cycle 8. in_valid during busy produces no extra accept.
- Self-loop s=s'=5, a=2 with Q(5,·)={0,0,0x0400,0}, r=0 -> scan uses old 0x0400; wdata=0x03E0.

Source files
------------

// File: rtl/q_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : q_pkg
//  Description : Shared widths, Q8.8 constants, FSM encoding and result
//                narrowing for the Q-table update engine. Build macro
//                QUPD_SATURATE_EN selects clamping instead of wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
package q_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int STATES_WIDTH = 4;
    localparam int ACTION_WIDTH = 2;
    localparam int ADDR_WIDTH   = STATES_WIDTH + ACTION_WIDTH;
    localparam int NUM_ACTIONS  = 2 ** ACTION_WIDTH;
    localparam int CALC_WIDTH   = DATA_WIDTH + 2;

    localparam logic signed [DATA_WIDTH-1:0] Q_ONE = (DATA_WIDTH)'(256);
    localparam logic signed [DATA_WIDTH-1:0] Q_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] Q_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CALC  = 2'd2,
        WRITE = 2'd3
    } q_state_t;

    // Bring the widened update result back to storage width.
    function automatic logic [DATA_WIDTH-1:0] q_narrow(input logic signed [CALC_WIDTH-1:0] v);
`ifdef QUPD_SATURATE_EN
        logic signed [CALC_WIDTH-1:0] hi;
        logic signed [CALC_WIDTH-1:0] lo;
        hi = {{2{Q_MAX[DATA_WIDTH-1]}}, Q_MAX};
        lo = {{2{Q_MIN[DATA_WIDTH-1]}}, Q_MIN};
        if (v > hi) begin
            return Q_MAX;
        end else if (v < lo) begin
            return Q_MIN;
        end else begin
            return v[DATA_WIDTH-1:0];
        end
`else
        return v[DATA_WIDTH-1:0];
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/q_update_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : q_update_engine_if
//  Description : Transition handshake plus Q-table RAM port bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface q_update_engine_if;
    import q_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [STATES_WIDTH-1:0] in_state;
    logic [ACTION_WIDTH-1:0] in_action;
    logic [DATA_WIDTH-1:0]   in_reward;
    logic [STATES_WIDTH-1:0] in_next_state;
    logic                    in_terminal;

    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr_cur;
    logic [ADDR_WIDTH-1:0]   ram_addr_nxt;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH-1:0]   ram_q_cur;
    logic [DATA_WIDTH-1:0]   ram_q_nxt;

    logic                    done;
    logic [ACTION_WIDTH-1:0] best_action;

    modport slave (
        input  in_valid, in_state, in_action, in_reward, in_next_state, in_terminal,
        input  ram_q_cur, ram_q_nxt,
        output in_ready, ram_we, ram_addr_cur, ram_addr_nxt, ram_wdata, done, best_action
    );

    modport master (
        output in_valid, in_state, in_action, in_reward, in_next_state, in_terminal,
        output ram_q_cur, ram_q_nxt,
        input  in_ready, ram_we, ram_addr_cur, ram_addr_nxt, ram_wdata, done, best_action
    );

endinterface
`default_nettype wire

// File: rtl/q_max_scan.sv
`default_nettype none
// ============================================================================
//  Module      : q_max_scan
//  Description : Running signed maximum with argmax; ties keep lower index.
//  Revision    : 1.0 - initial release
// ============================================================================
module q_max_scan
    import q_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         valid,
    input  logic signed [DATA_WIDTH-1:0] value,
    input  logic [ACTION_WIDTH-1:0]      index,
    output logic signed [DATA_WIDTH-1:0] max_val,
    output logic [ACTION_WIDTH-1:0]      best_idx
);

    logic signed [DATA_WIDTH-1:0] r_max;
    logic [ACTION_WIDTH-1:0]      r_best;
    logic                         w_take;

    // Index 0 seeds the maximum; later entries must be strictly greater.
    assign w_take = valid && ((index == '0) || (value > r_max));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max  <= '0;
            r_best <= '0;
        end else if (start) begin
            r_max  <= '0;
            r_best <= '0;
        end else if (w_take) begin
            r_max  <= value;
            r_best <= index;
        end
    end

    assign max_val  = r_max;
    assign best_idx = r_best;

endmodule
`default_nettype wire

// File: rtl/q_update_engine.sv
`default_nettype none
// ============================================================================
//  Module      : q_update_engine
//  Description : Accepts one (s,a,r,s',terminal) transition, scans Q(s',*)
//                for its maximum and writes back the Q-learning update.
//                QUPD_SATURATE_EN clamps the result instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module q_update_engine
    import q_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2,
    parameter int GAMMA_SHIFT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    q_update_engine_if.slave   bus
);

    localparam logic [ACTION_WIDTH:0] c_cnt_one = (ACTION_WIDTH+1)'(1);
    localparam logic [ACTION_WIDTH:0] c_num_act = (ACTION_WIDTH+1)'(NUM_ACTIONS);

    q_state_t                     r_state;
    q_state_t                     w_state_next;

    logic [ADDR_WIDTH-1:0]        r_addr_cur;
    logic [ADDR_WIDTH-1:0]        r_addr_nxt;
    logic [ACTION_WIDTH:0]        r_cnt;
    logic [ACTION_WIDTH:0]        w_cnt_inc;
    logic [ACTION_WIDTH:0]        w_cnt_dec;
    logic [STATES_WIDTH-1:0]      r_next_state;
    logic signed [DATA_WIDTH-1:0] r_reward;
    logic signed [DATA_WIDTH-1:0] r_q_cur;
    logic [DATA_WIDTH-1:0]        r_wdata;
    logic                         r_terminal;
    logic [ACTION_WIDTH-1:0]      r_best;

    logic                         w_accept;
    logic                         w_in_ready;
    logic                         w_we;
    logic                         w_scan_valid;
    logic signed [DATA_WIDTH-1:0] w_max;
    logic [ACTION_WIDTH-1:0]      w_max_idx;

    logic signed [CALC_WIDTH-1:0] w_max_ext;
    logic signed [CALC_WIDTH-1:0] w_reward_ext;
    logic signed [CALC_WIDTH-1:0] w_q_cur_ext;
    logic signed [CALC_WIDTH-1:0] w_fut_full;
    logic signed [CALC_WIDTH-1:0] w_fut;
    logic signed [CALC_WIDTH-1:0] w_td;
    logic signed [CALC_WIDTH-1:0] w_q_wide;

    assign w_accept  = (r_state == IDLE) && bus.in_valid;
    assign w_cnt_inc = r_cnt + c_cnt_one;
    assign w_cnt_dec = r_cnt - c_cnt_one;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_we         = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                if (r_cnt == c_num_act) begin
                    w_state_next = CALC;
                end
            end
            CALC: begin
                w_state_next = WRITE;
            end
            WRITE: begin
                w_we         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    // Read data for the address issued at count c arrives when count is c+1,
    // hence the comparison works on index cnt-1 and skips cnt==0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_cur   <= '0;
            r_addr_nxt   <= '0;
            r_cnt        <= '0;
            r_next_state <= '0;
            r_reward     <= '0;
            r_q_cur      <= '0;
            r_terminal   <= 1'b0;
            r_wdata      <= '0;
            r_best       <= '0;
        end else begin
            if (w_accept) begin
                r_addr_cur   <= {bus.in_state, bus.in_action};
                r_addr_nxt   <= {bus.in_next_state, {ACTION_WIDTH{1'b0}}};
                r_cnt        <= '0;
                r_next_state <= bus.in_next_state;
                r_reward     <= bus.in_reward;
                r_terminal   <= bus.in_terminal;
            end
            if (r_state == SCAN) begin
                if (w_cnt_inc < c_num_act) begin
                    r_addr_nxt <= {r_next_state, w_cnt_inc[ACTION_WIDTH-1:0]};
                end
                if (r_cnt != '0) begin
                    r_q_cur <= bus.ram_q_cur;
                end
                r_cnt <= w_cnt_inc;
            end
            if (r_state == CALC) begin
                r_wdata <= q_narrow(w_q_wide);
                r_best  <= w_max_idx;
            end
        end
    end

    assign w_scan_valid = (r_state == SCAN) && (r_cnt != '0);

    q_max_scan u_max_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_accept),
        .valid    (w_scan_valid),
        .value    (bus.ram_q_nxt),
        .index    (w_cnt_dec[ACTION_WIDTH-1:0]),
        .max_val  (w_max),
        .best_idx (w_max_idx)
    );

    // Update arithmetic carried two bits wider so the sum cannot overflow.
    assign w_max_ext    = {{2{w_max[DATA_WIDTH-1]}}, w_max};
    assign w_reward_ext = {{2{r_reward[DATA_WIDTH-1]}}, r_reward};
    assign w_q_cur_ext  = {{2{r_q_cur[DATA_WIDTH-1]}}, r_q_cur};
    assign w_fut_full   = w_max_ext - (w_max_ext >>> GAMMA_SHIFT);
    assign w_fut        = r_terminal ? {CALC_WIDTH{1'b0}} : w_fut_full;
    assign w_td         = w_reward_ext + w_fut - w_q_cur_ext;
    assign w_q_wide     = w_q_cur_ext + (w_td >>> ALPHA_SHIFT);

    assign bus.in_ready     = w_in_ready;
    assign bus.ram_we       = w_we;
    assign bus.done         = w_we;
    assign bus.ram_addr_cur = r_addr_cur;
    assign bus.ram_addr_nxt = r_addr_nxt;
    assign bus.ram_wdata    = r_wdata;
    assign bus.best_action  = r_best;

endmodule
`default_nettype wire

// File: tb/tb_q_update_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_q_update_engine
//  Description : Scoreboard bench for q_update_engine with a Q-table RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_q_update_engine;
    import q_pkg::*;

    logic clk;
    logic rst_n;

    q_update_engine_if bus();

    q_update_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q-table RAM model: registered reads, negedge write
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always @(posedge clk) begin
        bus.ram_q_cur <= mem[bus.ram_addr_cur];
        bus.ram_q_nxt <= mem[bus.ram_addr_nxt];
    end

    always @(negedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr_cur] = bus.ram_wdata;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    typedef struct {
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   wdata;
        logic [ACTION_WIDTH-1:0] best;
    } exp_t;

    exp_t sb[$];

    int cyc      = 0;
    int acc      = 0;
    int prev_acc = 0;
    int n_acc    = 0;
    int n_writes = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.in_valid && bus.in_ready) begin
            n_acc    <= n_acc + 1;
            prev_acc <= acc;
            acc      <= cyc;
        end
    end

    // Monitor: every write pulse is popped and compared against the scoreboard
    always @(negedge clk) begin
        if (rst_n && (bus.ram_we || bus.done)) begin
            exp_t e;
            n_writes++;
            check("we_high", {31'd0, bus.ram_we}, 32'd1);
            check("done_high", {31'd0, bus.done}, 32'd1);
            check("latency", cyc - acc, 32'd7);
            if (sb.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("addr", {26'd0, bus.ram_addr_cur}, {26'd0, e.addr});
                check("wdata", {16'd0, bus.ram_wdata}, {16'd0, e.wdata});
                check("best_action", {30'd0, bus.best_action}, {30'd0, e.best});
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] = '0;
    endtask

    task automatic drive(input logic [3:0] s, input logic [1:0] a, input logic [15:0] r,
                         input logic [3:0] sn, input logic t);
        bus.in_state      = s;
        bus.in_action     = a;
        bus.in_reward     = r;
        bus.in_next_state = sn;
        bus.in_terminal   = t;
        bus.in_valid      = 1'b1;
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_writes(input int target);
        int k = 0;
        while (n_writes < target && k < 30) begin
            @(posedge clk);
            k++;
        end
        if (n_writes < target) check("write_timeout", n_writes, target);
    endtask

    task automatic run_one(input logic [3:0] s, input logic [1:0] a, input logic [15:0] r,
                           input logic [3:0] sn, input logic t,
                           input logic [15:0] w, input logic [1:0] b);
        int base;
        base = n_writes;
        wait_ready();
        drive(s, a, r, sn, t);
        sb.push_back('{addr: {s, a}, wdata: w, best: b});
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("busy_ready", {31'd0, bus.in_ready}, 32'd0);
        wait_writes(base + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({tag, "_ram_we"},   {31'd0, bus.ram_we}, 32'd0);
        check({tag, "_done"},     {31'd0, bus.done}, 32'd0);
        check({tag, "_addr_cur"}, {26'd0, bus.ram_addr_cur}, 32'd0);
        check({tag, "_addr_nxt"}, {26'd0, bus.ram_addr_nxt}, 32'd0);
        check({tag, "_wdata"},    {16'd0, bus.ram_wdata}, 32'd0);
        check({tag, "_best"},     {30'd0, bus.best_action}, 32'd0);
    endtask

    task automatic preload_basic();
        clear_mem();
        mem[{4'd2, 2'd1}] = 16'h0100;
        mem[{4'd3, 2'd0}] = 16'h0080;
        mem[{4'd3, 2'd1}] = 16'h0200;
        mem[{4'd3, 2'd2}] = 16'hFF00;
        mem[{4'd3, 2'd3}] = 16'h0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_w;
        int base_a;
        logic [15:0] sat_exp;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_state = '0;
        bus.in_action = '0;
        bus.in_reward = '0;
        bus.in_next_state = '0;
        bus.in_terminal = 1'b0;
        clear_mem();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic update: max=0x200 at index 1, q_new=0x170
        preload_basic();
        run_one(4'd2, 2'd1, 16'h0100, 4'd3, 1'b0, 16'h0170, 2'd1);

        // Terminal: future term dropped, td=0
        preload_basic();
        run_one(4'd2, 2'd1, 16'h0100, 4'd3, 1'b1, 16'h0100, 2'd1);

        // Self-loop reads the pre-update value
        clear_mem();
        mem[{4'd5, 2'd2}] = 16'h0400;
        run_one(4'd5, 2'd2, 16'h0000, 4'd5, 1'b0, 16'h03E0, 2'd2);

        // Reset in the middle of the scan abandons the transition
        preload_basic();
        base_w = n_writes;
        wait_ready();
        drive(4'd2, 2'd1, 16'h0100, 4'd3, 1'b0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_no_write", n_writes, base_w);
        check_reset_outputs("postrst");

        // Overflowing update: clamps or wraps depending on the build
`ifdef QUPD_SATURATE_EN
        sat_exp = 16'h7FFF;
`else
        sat_exp = 16'h9AC8;
`endif
        clear_mem();
        mem[{4'd1, 2'd3}] = 16'h7F00;
        for (int i = 0; i < NUM_ACTIONS; i++) mem[{4'd4, i[1:0]}] = 16'h7F00;
        run_one(4'd1, 2'd3, 16'h7F00, 4'd4, 1'b0, sat_exp, 2'd0);

        // Back-to-back with in_valid held: second accept 8 cycles later and
        // its read of Q(2,1) sees the first write (0x170 -> 0x114)
        preload_basic();
        base_w = n_writes;
        base_a = n_acc;
        wait_ready();
        drive(4'd2, 2'd1, 16'h0100, 4'd3, 1'b0);
        sb.push_back('{addr: {4'd2, 2'd1}, wdata: 16'h0170, best: 2'd1});
        @(posedge clk);
        #1;
        drive(4'd2, 2'd1, 16'h0000, 4'd3, 1'b1);
        sb.push_back('{addr: {4'd2, 2'd1}, wdata: 16'h0114, best: 2'd1});
        for (int k = 0; k < 20 && n_acc < base_a + 2; k++) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("b2b_accepts", n_acc - base_a, 32'd2);
        check("b2b_spacing", acc - prev_acc, 32'd8);
        wait_writes(base_w + 2);
        repeat (10) @(posedge clk);
        #1;
        check("b2b_no_extra_accept", n_acc - base_a, 32'd2);
        check("b2b_writes", n_writes - base_w, 32'd2);
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
